// File: rtl/cipher_char_sequencer.sv
// Byte-stream front end for the S-box stream cipher: letters go through the cipher one at
// a time, every other byte bypasses it, and output order always matches input order.
module cipher_char_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic [7:0] key_in,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       cph_din_valid,
    output logic [7:0] cph_key,
    output logic [7:0] cph_txt_in,
    input  logic [7:0] cph_txt_out,
    input  logic       cph_dout_ready,
    output logic       err_timeout,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        empty, full, push, pop;
    logic [7:0]  head;

    state_t      state_reg, state_next;
    logic [7:0]  hold_reg, hold_next;
    logic [7:0]  out_reg, out_next;
    logic [7:0]  key_reg, key_next;
    logic [7:0]  wait_reg, wait_next;
    logic        err_reg, err_next;
    logic [7:0]  wait_inc;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    // The wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign push  = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign wait_inc = wait_reg + 8'd1;

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        out_next   = out_reg;
        key_next   = key_reg;
        wait_next  = wait_reg;
        err_next   = err_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    key_next = key_in;
                    if (is_letter(head)) begin
                        hold_next  = head;
                        state_next = ISSUE;
                    end else begin
                        out_next   = head;
                        state_next = EMIT;
                    end
                end
            end
            ISSUE: begin
                wait_next  = 8'd0;
                state_next = WAIT;
            end
            WAIT: begin
                // wait_cnt counts completed WAIT cycles; abort once TIMEOUT of them pass.
                wait_next = wait_inc;
                if (cph_dout_ready) begin
                    out_next   = cph_txt_out;
                    state_next = EMIT;
                end else if (wait_inc == TIMEOUT_C) begin
                    err_next   = 1'b1;
                    out_next   = hold_reg;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (m_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hold_reg  <= 8'd0;
            out_reg   <= 8'd0;
            key_reg   <= 8'd0;
            wait_reg  <= 8'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            out_reg   <= out_next;
            key_reg   <= key_next;
            wait_reg  <= wait_next;
            err_reg   <= err_next;
        end
    end

    assign s_ready       = !rst && !full;
    assign m_valid       = (state_reg == EMIT);
    assign m_data        = out_reg;
    assign cph_din_valid = (state_reg == ISSUE);
    assign cph_key       = key_reg;
    assign cph_txt_in    = hold_reg;
    assign err_timeout   = err_reg;
    assign busy          = (state_reg != IDLE) || !empty;
endmodule

// File: tb/tb_cipher_char_sequencer.sv
// Randomized bench for cipher_char_sequencer with a queue-based reference model and a
// simple cipher stand-in that answers one cycle after each din_valid pulse.
module tb_cipher_char_sequencer;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic [7:0] key_in = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       cph_din_valid;
    logic [7:0] cph_key;
    logic [7:0] cph_txt_in;
    logic [7:0] cph_txt_out = 8'h00;
    logic       cph_dout_ready = 1'b0;
    logic       err_timeout;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit cipher_on = 1'b1;

    // Values observed at the negedge of the most recent step
    logic       acc, ofire, obs_mv, obs_dv, obs_sr, obs_err, obs_busy;
    logic [7:0] odata, obs_txt, obs_key;

    cipher_char_sequencer #(.FIFO_DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .key_in(key_in), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .cph_din_valid(cph_din_valid), .cph_key(cph_key), .cph_txt_in(cph_txt_in),
        .cph_txt_out(cph_txt_out), .cph_dout_ready(cph_dout_ready),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_cipher(input logic [7:0] t, input logic [7:0] k);
        return t ^ k ^ 8'hE3;
    endfunction

    function automatic logic [7:0] ref_out(input logic [7:0] b, input logic [7:0] k, input bit on);
        bit letter;
        letter = (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
        return (letter && on) ? ref_cipher(b, k) : b;
    endfunction

    // Cipher stand-in: answers in the cycle after a din_valid cycle, unless disabled.
    logic       fire_s = 1'b0;
    logic [7:0] txt_s = 8'h00, key_s = 8'h00;
    always @(negedge clk) begin
        fire_s = cph_din_valid;
        txt_s  = cph_txt_in;
        key_s  = cph_key;
    end
    always @(posedge clk) begin
        #1;
        cph_dout_ready = fire_s && cipher_on && !rst;
        cph_txt_out    = fire_s ? ref_cipher(txt_s, key_s) : 8'h00;
    end

    task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        acc = s_valid && s_ready;
        ofire = m_valid && m_ready;
        odata = m_data;
        obs_mv = m_valid; obs_dv = cph_din_valid; obs_sr = s_ready;
        obs_err = err_timeout; obs_busy = busy; obs_txt = cph_txt_in; obs_key = cph_key;
        @(posedge clk);
        #1;
    endtask

    // Stimulus driver only; callers compare its results with the reference model.
    // mode: 0 m_ready=1, 1 m_ready=0 for 25 cycles then 1, 2 toggling, 3 random with input gaps
    task automatic stream(input logic [7:0] bytes[$], input int mode, output logic [7:0] outs[$],
                          output int dv_cnt, output int stall_bad, output bit full_seen);
        int i, cyc;
        logic mr, sv, prev_stall;
        logic [7:0] prev_data;
        i = 0; cyc = 0; prev_stall = 1'b0; prev_data = 8'h00;
        outs.delete(); dv_cnt = 0; stall_bad = 0; full_seen = 1'b0;
        while ((i < bytes.size() || outs.size() < bytes.size()) && cyc < 2000) begin
            case (mode)
                0: mr = 1'b1;
                1: mr = (cyc >= 25);
                2: mr = (cyc % 2 == 0);
                default: mr = 1'($urandom_range(0, 1));
            endcase
            sv = (i < bytes.size()) && (mode != 3 || $urandom_range(0, 3) != 0);
            step(sv, sv ? bytes[i] : 8'h00, mr);
            if (prev_stall && (!obs_mv || odata !== prev_data)) stall_bad++;
            prev_stall = obs_mv && !mr;
            prev_data  = odata;
            if (acc) i++;
            if (sv && !acc) full_seen = 1'b1;
            if (ofire) outs.push_back(odata);
            if (obs_dv) dv_cnt++;
            cyc++;
        end
    endtask

    function automatic bit same(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[k]) if (a[k] !== b[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        step(1'b1, 8'h41, 1'b1);
        step(1'b1, 8'h41, 1'b1);
        tests++; if (obs_sr !== 1'b0) begin fails++; $display("FAIL reset_s_ready_low: got %b want 0", obs_sr); end
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        tests++; if (obs_sr !== 1'b1) begin fails++; $display("FAIL reset_s_ready_high: got %b want 1", obs_sr); end
        tests++; if (obs_mv !== 1'b0 || odata !== 8'h00) begin fails++; $display("FAIL reset_m: got valid=%b data=%h want 0/00", obs_mv, odata); end
        tests++; if (obs_dv !== 1'b0 || obs_txt !== 8'h00 || obs_key !== 8'h00) begin fails++; $display("FAIL reset_cph: got dv=%b txt=%h key=%h want 0/00/00", obs_dv, obs_txt, obs_key); end
        tests++; if (obs_err !== 1'b0 || obs_busy !== 1'b0) begin fails++; $display("FAIL reset_flags: got err=%b busy=%b want 0/0", obs_err, obs_busy); end
    endtask

    task automatic test_letter;
        int dv_cnt, out_step;
        logic [7:0] got;
        key_in = 8'h3C; cipher_on = 1'b1; dv_cnt = 0; out_step = -1; got = 8'h00;
        step(1'b1, 8'h41, 1'b1);
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL letter_accept: got %b want 1", acc); end
        for (int n = 1; n < 12; n++) begin
            step(1'b0, 8'h00, 1'b1);
            if (obs_dv) begin
                dv_cnt++;
                tests++; if (obs_txt !== 8'h41 || obs_key !== 8'h3C) begin fails++; $display("FAIL letter_issue: got txt=%h key=%h want 41/3c", obs_txt, obs_key); end
            end
            if (ofire && out_step < 0) begin out_step = n; got = odata; end
        end
        tests++; if (dv_cnt != 1) begin fails++; $display("FAIL letter_dv_pulses: got %0d want 1", dv_cnt); end
        tests++; if (got !== 8'h9E) begin fails++; $display("FAIL letter_data: got %h want 9e", got); end
        tests++; if (out_step != 4) begin fails++; $display("FAIL letter_latency: got cycle %0d want 4", out_step); end
    endtask

    task automatic test_bypass;
        logic [7:0] bytes[$], outs[$];
        int dv_cnt, stall_bad, out_step;
        bit full_seen;
        out_step = -1;
        step(1'b1, 8'h20, 1'b1);
        for (int n = 1; n < 8; n++) begin
            step(1'b0, 8'h00, 1'b1);
            if (ofire && out_step < 0) out_step = n;
        end
        tests++; if (out_step != 2) begin fails++; $display("FAIL bypass_latency: got cycle %0d want 2", out_step); end
        bytes = '{8'h20, 8'h37, 8'h0A};
        stream(bytes, 0, outs, dv_cnt, stall_bad, full_seen);
        tests++; if (!same(outs, bytes)) begin fails++; $display("FAIL bypass_data: got %0d bytes %p want %p", outs.size(), outs, bytes); end
        tests++; if (dv_cnt != 0) begin fails++; $display("FAIL bypass_no_issue: got %0d din_valid cycles want 0", dv_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[$], outs[$], exp[$];
        int dv_cnt, stall_bad;
        bit full_seen;
        key_in = 8'($urandom);
        for (int k = 0; k < 10; k++) begin
            bytes.push_back((k % 2 == 0) ? 8'(8'h61 + k) : 8'(8'h30 + k));
            exp.push_back(ref_out(bytes[k], key_in, 1'b1));
        end
        stream(bytes, 1, outs, dv_cnt, stall_bad, full_seen);
        tests++; if (full_seen !== 1'b1) begin fails++; $display("FAIL b2b_full: got s_ready never low want low when full"); end
        tests++; if (!same(outs, exp)) begin fails++; $display("FAIL b2b_data: got %p want %p", outs, exp); end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL b2b_stall: got %0d unstable stalls want 0", stall_bad); end
    endtask

    task automatic test_timeout;
        logic [7:0] bytes[$], outs[$], exp[$];
        int out_step, dv_cnt, stall_bad;
        bit full_seen;
        logic [7:0] got;
        cipher_on = 1'b0; out_step = -1; got = 8'h00;
        step(1'b1, 8'h7A, 1'b1);
        for (int n = 1; n < 40 && out_step < 0; n++) begin
            step(1'b0, 8'h00, 1'b1);
            if (ofire) begin out_step = n; got = odata; end
        end
        tests++; if (out_step < TIMEOUT + 3 || out_step > TIMEOUT + 4) begin fails++; $display("FAIL timeout_latency: got cycle %0d want %0d..%0d", out_step, TIMEOUT + 3, TIMEOUT + 4); end
        tests++; if (got !== 8'h7A) begin fails++; $display("FAIL timeout_data: got %h want 7a", got); end
        tests++; if (obs_err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", obs_err); end
        cipher_on = 1'b1;
        bytes = '{8'h62};
        exp = '{ref_out(8'h62, key_in, 1'b1)};
        stream(bytes, 0, outs, dv_cnt, stall_bad, full_seen);
        tests++; if (!same(outs, exp) || obs_err !== 1'b1) begin fails++; $display("FAIL timeout_next: got %p err=%b want %p err=1", outs, obs_err, exp); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] bytes[4];
        int leaked;
        cipher_on = 1'b0; leaked = 0; key_in = 8'h5A;
        bytes = '{8'h71, 8'h31, 8'h32, 8'h33};
        foreach (bytes[k]) step(1'b1, bytes[k], 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        tests++; if (obs_mv !== 1'b0 || odata !== 8'h00 || obs_sr !== 1'b1) begin fails++; $display("FAIL rstmid_m: got valid=%b data=%h s_ready=%b want 0/00/1", obs_mv, odata, obs_sr); end
        tests++; if (obs_dv !== 1'b0 || obs_txt !== 8'h00 || obs_key !== 8'h00) begin fails++; $display("FAIL rstmid_cph: got dv=%b txt=%h key=%h want 0/00/00", obs_dv, obs_txt, obs_key); end
        tests++; if (obs_err !== 1'b0 || obs_busy !== 1'b0) begin fails++; $display("FAIL rstmid_flags: got err=%b busy=%b want 0/0", obs_err, obs_busy); end
        cipher_on = 1'b1;
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 8'h00, 1'b1);
            if (obs_mv) leaked++;
        end
        tests++; if (leaked != 0) begin fails++; $display("FAIL rstmid_dropped: got %0d output cycles want 0", leaked); end
    endtask

    task automatic test_stall_toggle;
        logic [7:0] bytes[$], outs[$], exp[$];
        int dv_cnt, stall_bad;
        bit full_seen;
        key_in = 8'hA7;
        bytes = '{8'h48, 8'h69, 8'h21};
        foreach (bytes[k]) exp.push_back(ref_out(bytes[k], key_in, 1'b1));
        stream(bytes, 2, outs, dv_cnt, stall_bad, full_seen);
        tests++; if (!same(outs, exp)) begin fails++; $display("FAIL toggle_data: got %p want %p", outs, exp); end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL toggle_stable: got %0d unstable stalls want 0", stall_bad); end
        tests++; if (dv_cnt != 2) begin fails++; $display("FAIL toggle_issues: got %0d want 2", dv_cnt); end
    endtask

    task automatic test_random;
        logic [7:0] bytes[$], outs[$], exp[$];
        int dv_cnt, stall_bad, letters;
        bit full_seen;
        for (int r = 0; r < 3; r++) begin
            bytes.delete(); exp.delete(); letters = 0;
            key_in = 8'($urandom);
            for (int k = 0; k < 30; k++) begin
                logic [7:0] b;
                int sel;
                sel = int'($urandom_range(0, 51));
                if ($urandom_range(0, 1) == 0) b = (sel < 26) ? 8'(8'h41 + sel) : 8'(8'h61 + sel - 26);
                else b = 8'($urandom);
                bytes.push_back(b);
                exp.push_back(ref_out(b, key_in, 1'b1));
                if (exp[k] != b || ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))) letters++;
            end
            stream(bytes, 3, outs, dv_cnt, stall_bad, full_seen);
            tests++; if (!same(outs, exp)) begin fails++; $display("FAIL random_data[%0d]: got %p want %p", r, outs, exp); end
            tests++; if (stall_bad != 0 || dv_cnt != letters) begin fails++; $display("FAIL random_ctrl[%0d]: got stalls=%0d issues=%0d want 0/%0d", r, stall_bad, dv_cnt, letters); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_letter();
        test_bypass();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_stall_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
